// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, fault codes and defaults.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;

    localparam logic [31:0] DEFAULT_NOP_INSTR  = 32'hD503201F;
    localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h80000000;
    localparam int unsigned DEFAULT_TIMEOUT    = 16;

    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts request cycles without an ack; expired fires in the TIMEOUT-th such cycle.
module fetch_timeout_counter #(
    parameter int unsigned TIMEOUT = 16,
    localparam int unsigned W      = $clog2(TIMEOUT + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Combinational so the fault edge lands exactly TIMEOUT cycles after issue.
    assign expired = enable && !clear && (count_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: one outstanding req/ack memory read per PC, loading the IR for decode.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR,
    parameter logic [31:0] NOP_INSTR  = DEFAULT_NOP_INSTR,
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        flush,
    output logic        pc_advance,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir_out,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        fault,
    output logic [1:0]  fault_code
);

    fetch_state_e state_q, state_d;

    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] ir_out_q, ir_out_d;
    logic [31:0] ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic        fault_q, fault_d;
    logic [1:0]  fault_code_q, fault_code_d;

    logic issue_ok;
    logic misaligned;
    logic in_flight;
    logic issue;
    logic capture;
    logic retire;
    logic tmo_enable;
    logic tmo_expired;

    // Issuing only into an empty (or draining) IR means an ack never needs a skid buffer.
    assign issue_ok   = !flush && (!ir_valid_q || ir_ready);
    assign misaligned = pc_misaligned(pc_in[1:0]);
    assign in_flight  = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
    assign tmo_enable = in_flight && !mem_ack;

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (issue),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_REQ: begin
                if (issue_ok) begin
                    state_d = misaligned ? ST_FAULT : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    state_d = ST_REQ;
                end else if (tmo_expired) begin
                    state_d = ST_FAULT;
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (mem_ack) begin
                    state_d = ST_REQ;
                end else if (tmo_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_REQ;
        endcase
    end

    always_comb begin
        issue      = (state_q == ST_REQ) && issue_ok && !misaligned;
        capture    = (state_q == ST_WAIT) && mem_ack && !flush;
        retire     = in_flight && mem_ack;
        pc_advance = capture;

        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        ir_out_d     = ir_out_q;
        ir_pc_d      = ir_pc_q;
        ir_valid_d   = ir_valid_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;

        if (issue) begin
            mem_req_d  = 1'b1;
            mem_addr_d = pc_in;
        end else if (retire || (in_flight && tmo_expired) || state_q == ST_FAULT) begin
            mem_req_d = 1'b0;
        end

        if (state_q == ST_FAULT) begin
            ir_valid_d = 1'b0;
            ir_out_d   = NOP_INSTR;
        end else if (capture) begin
            ir_valid_d = 1'b1;
            ir_out_d   = mem_rdata;
            ir_pc_d    = mem_addr_q;
        end else if (flush || (ir_valid_q && ir_ready)) begin
            ir_valid_d = 1'b0;
            ir_out_d   = NOP_INSTR;
        end

        if (state_q == ST_REQ && issue_ok && misaligned) begin
            fault_d      = 1'b1;
            fault_code_d = FC_MISALIGN;
        end else if (in_flight && tmo_expired) begin
            fault_d      = 1'b1;
            fault_code_d = FC_TIMEOUT;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            ir_out_q     <= NOP_INSTR;
            ir_pc_q      <= RESET_ADDR;
            ir_valid_q   <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
        end else begin
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            ir_out_q     <= ir_out_d;
            ir_pc_q      <= ir_pc_d;
            ir_valid_q   <= ir_valid_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign ir_out     = ir_out_q;
    assign ir_pc      = ir_pc_q;
    assign ir_valid   = ir_valid_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;

endmodule
